// File: rtl/seven_seg_scanner_if.sv
// Stopwatch digit bus toward the 7-segment scanner, plus the active-low display drive back out.
// master: stopwatch/test side that drives digits and pause; slave: the scanner.
interface seven_seg_scanner_if;
    logic [2:0] m10;
    logic [3:0] m1;
    logic [2:0] s10;
    logic [3:0] s1;
    logic       pause;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output m10, m1, s10, s1, pause,
        input  an, seg, dp
    );

    modport slave (
        input  m10, m1, s10, s1, pause,
        output an, seg, dp
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Scans a once-per-frame snapshot of four BCD digits onto a common-anode 4-digit display.
// Optional pause blinking is built only when BLINK_ON_PAUSE_EN is defined.
module seven_seg_scanner #(
    parameter int unsigned SCAN_DIV  = 4,
    parameter int unsigned BLINK_DIV = 256
) (
    input logic               clkDis,
    input logic               rst,
    seven_seg_scanner_if.slave bus
);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        DIG_S1  = 2'd0,
        DIG_S10 = 2'd1,
        DIG_M1  = 2'd2,
        DIG_M10 = 2'd3
    } digit_e;

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    digit_e            idx_q, idx_d;
    logic [2:0]        m10_q, m10_d;
    logic [3:0]        m1_q, m1_d;
    logic [2:0]        s10_q, s10_d;
    logic [3:0]        s1_q, s1_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        digit;
    logic [3:0]        digit_max;
    logic              frame_end;

    function automatic logic [6:0] seg_decode(input logic [3:0] val, input logic [3:0] max_val);
        logic [6:0] pat;
        pat = '1;
        if (val <= max_val) begin
            unique case (val)
                4'd0:    pat = 7'b1000000;
                4'd1:    pat = 7'b1111001;
                4'd2:    pat = 7'b0100100;
                4'd3:    pat = 7'b0110000;
                4'd4:    pat = 7'b0011001;
                4'd5:    pat = 7'b0010010;
                4'd6:    pat = 7'b0000010;
                4'd7:    pat = 7'b1111000;
                4'd8:    pat = 7'b0000000;
                4'd9:    pat = 7'b0010000;
                default: pat = '1;
            endcase
        end
        return pat;
    endfunction

`ifdef BLINK_ON_PAUSE_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               blank;

    always_comb begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        blank = bus.pause & blink_phase_q;
    end

    always_ff @(posedge clkDis) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    logic blank;
    logic unused_cfg;

    always_comb begin
        blank      = 1'b0;
        unused_cfg = ^{bus.pause, BLINK_DIV};
    end
`endif

    always_comb begin
        frame_end  = (scan_cnt_q == SCAN_LAST) && (idx_q == DIG_M10);
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            unique case (idx_q)
                DIG_S1:  idx_d = DIG_S10;
                DIG_S10: idx_d = DIG_M1;
                DIG_M1:  idx_d = DIG_M10;
                DIG_M10: idx_d = DIG_S1;
                default: idx_d = DIG_S1;
            endcase
        end

        // Snapshot only at frame end, so one frame never mixes two time values.
        m10_d = frame_end ? bus.m10 : m10_q;
        m1_d  = frame_end ? bus.m1  : m1_q;
        s10_d = frame_end ? bus.s10 : s10_q;
        s1_d  = frame_end ? bus.s1  : s1_q;

        digit     = s1_q;
        digit_max = 4'd9;
        unique case (idx_q)
            DIG_S1:  begin digit = s1_q;          digit_max = 4'd9; end
            DIG_S10: begin digit = {1'b0, s10_q}; digit_max = 4'd5; end
            DIG_M1:  begin digit = m1_q;          digit_max = 4'd9; end
            DIG_M10: begin digit = {1'b0, m10_q}; digit_max = 4'd5; end
            default: begin digit = s1_q;          digit_max = 4'd9; end
        endcase

        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_decode(digit, digit_max);
        dp_d  = (idx_q != DIG_M1);
        if (blank) begin
            an_d = '1;
            dp_d = 1'b1;
        end
    end

    always_ff @(posedge clkDis) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= DIG_S1;
            m10_q      <= '0;
            m1_q       <= '0;
            s10_q      <= '0;
            s1_q       <= '0;
            an_q       <= '1;
            seg_q      <= '1;
            dp_q       <= 1'b1;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            m10_q      <= m10_d;
            m1_q       <= m1_d;
            s10_q      <= s10_d;
            s1_q       <= s1_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (SCAN_DIV=4, BLINK_DIV=16); blink checks follow BLINK_ON_PAUSE_EN.
module tb_seven_seg_scanner;
    logic clkDis;
    logic rst;
    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned cyc;

    localparam logic [6:0] SEG_0  = 7'b1000000;
    localparam logic [6:0] SEG_1  = 7'b1111001;
    localparam logic [6:0] SEG_2  = 7'b0100100;
    localparam logic [6:0] SEG_3  = 7'b0110000;
    localparam logic [6:0] SEG_4  = 7'b0011001;
    localparam logic [6:0] SEG_5  = 7'b0010010;
    localparam logic [6:0] SEG_9  = 7'b0010000;
    localparam logic [6:0] SEG_BL = 7'b1111111;

    logic [3:0] exp_an [4];

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(
        .SCAN_DIV  (4),
        .BLINK_DIV (16)
    ) dut (
        .clkDis (clkDis),
        .rst    (rst),
        .bus    (bus.slave)
    );

    initial begin
        clkDis = 1'b0;
        forever #5 clkDis = ~clkDis;
    end

    // One clkDis edge has passed when this returns; outputs are read on the falling edge.
    task automatic tick();
        @(negedge clkDis);
        cyc++;
    endtask

    task automatic set_digits(input logic [2:0] m10, input logic [3:0] m1,
                              input logic [2:0] s10, input logic [3:0] s1);
        bus.m10 = m10;
        bus.m1  = m1;
        bus.s10 = s10;
        bus.s1  = s1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        set_digits(3'd1, 4'd2, 3'd3, 4'd4);
        bus.pause = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.an, bus.seg, bus.dp} !== {4'b1111, SEG_BL, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1",
                     bus.an, bus.seg, bus.dp);
        end
        rst = 1'b0;
        cyc = 0;
        tick();
        n_checks++;
        if ({bus.an, bus.seg, bus.dp} !== {4'b1110, SEG_0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: an=%b seg=%b dp=%b expected an=1110 seg=1000000 dp=1",
                     bus.an, bus.seg, bus.dp);
        end
    endtask

    // Continues from test_reset: digits 1,2,3,4 held; cycle 1 already checked.
    task automatic test_scan_frames();
        logic [6:0] f2_seg [4];
        logic [6:0] es;
        int unsigned d;
        f2_seg[0] = SEG_4; f2_seg[1] = SEG_3; f2_seg[2] = SEG_2; f2_seg[3] = SEG_1;
        for (int k = 2; k <= 32; k++) begin
            tick();
            d  = ((cyc - 1) / 4) % 4;
            es = (cyc <= 16) ? SEG_0 : f2_seg[d];
            n_checks++;
            if ({bus.an, bus.seg, bus.dp} !== {exp_an[d], es, (d != 2)}) begin
                n_fail++;
                $display("FAIL scan_frames cyc=%0d: an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                         cyc, bus.an, bus.seg, bus.dp, exp_an[d], es, (d != 2));
            end
        end
    endtask

    // Frame 3 (cycles 33..48): s1 changes 4->5 during idx 2; frame 4 idx 0 shows 5.
    task automatic test_snapshot_coherency();
        logic [6:0] f_seg [4];
        logic [6:0] es;
        int unsigned d;
        f_seg[0] = SEG_4; f_seg[1] = SEG_3; f_seg[2] = SEG_2; f_seg[3] = SEG_1;
        for (int k = 33; k <= 52; k++) begin
            tick();
            if (cyc == 41) bus.s1 = 4'd5;
            d  = ((cyc - 1) / 4) % 4;
            es = (cyc <= 48) ? f_seg[d] : SEG_5;
            n_checks++;
            if ({bus.an, bus.seg} !== {exp_an[d], es}) begin
                n_fail++;
                $display("FAIL snapshot_coherency cyc=%0d: an=%b seg=%b expected an=%b seg=%b",
                         cyc, bus.an, bus.seg, exp_an[d], es);
            end
        end
    endtask

    task automatic test_illegal_digits();
        logic [6:0] e1 [4];
        logic [6:0] e2 [4];
        int unsigned d;
        e1[0] = SEG_4; e1[1] = SEG_3; e1[2] = SEG_BL; e1[3] = SEG_1;
        e2[0] = SEG_0; e2[1] = SEG_5; e2[2] = SEG_9;  e2[3] = SEG_BL;
        set_digits(3'd1, 4'hA, 3'd3, 4'd4);
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (cyc > 16) begin
                d = ((cyc - 1) / 4) % 4;
                n_checks++;
                if ({bus.an, bus.seg, bus.dp} !== {exp_an[d], e1[d], (d != 2)}) begin
                    n_fail++;
                    $display("FAIL illegal_m1 cyc=%0d: an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                             cyc, bus.an, bus.seg, bus.dp, exp_an[d], e1[d], (d != 2));
                end
            end
        end
        set_digits(3'd6, 4'd9, 3'd5, 4'd0);
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (cyc > 16) begin
                d = ((cyc - 1) / 4) % 4;
                n_checks++;
                if ({bus.an, bus.seg} !== {exp_an[d], e2[d]}) begin
                    n_fail++;
                    $display("FAIL illegal_m10 cyc=%0d: an=%b seg=%b expected an=%b seg=%b",
                             cyc, bus.an, bus.seg, exp_an[d], e2[d]);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [3:0] ea;
        logic       edp;
        int unsigned d;
        set_digits(3'd1, 4'd2, 3'd3, 4'd4);
        bus.pause = 1'b1;
        do_reset();
`ifdef BLINK_ON_PAUSE_EN
        for (int k = 1; k <= 20; k++) begin
            tick();
            d   = ((cyc - 1) / 4) % 4;
            ea  = (cyc >= 17) ? 4'b1111 : exp_an[d];
            edp = (cyc >= 17) ? 1'b1 : (d != 2);
            n_checks++;
            if ({bus.an, bus.dp} !== {ea, edp}) begin
                n_fail++;
                $display("FAIL blink_on cyc=%0d: an=%b dp=%b expected an=%b dp=%b",
                         cyc, bus.an, bus.dp, ea, edp);
            end
        end
        bus.pause = 1'b0;
        tick();
        n_checks++;
        if (bus.an !== 4'b1101) begin
            n_fail++;
            $display("FAIL blink_resume: an=%b expected 1101", bus.an);
        end
`else
        for (int k = 1; k <= 64; k++) begin
            tick();
            d = ((cyc - 1) / 4) % 4;
            n_checks++;
            if (bus.an !== exp_an[d]) begin
                n_fail++;
                $display("FAIL blink_off cyc=%0d: an=%b expected %b", cyc, bus.an, exp_an[d]);
            end
        end
`endif
        bus.pause = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        set_digits(3'd1, 4'd2, 3'd3, 4'd4);
        do_reset();
        for (int k = 1; k <= 26; k++) tick();
        n_checks++;
        if ({bus.an, bus.seg, bus.dp} !== {4'b1011, SEG_2, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_frame_pre: an=%b seg=%b dp=%b expected an=1011 seg=0100100 dp=0",
                     bus.an, bus.seg, bus.dp);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bus.an, bus.seg, bus.dp} !== {4'b1111, SEG_BL, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_frame_reset: an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1",
                     bus.an, bus.seg, bus.dp);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({bus.an, bus.seg, bus.dp} !== {4'b1110, SEG_0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_frame_release: an=%b seg=%b dp=%b expected an=1110 seg=1000000 dp=1",
                     bus.an, bus.seg, bus.dp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
        set_digits(3'd0, 4'd0, 3'd0, 4'd0);
        bus.pause = 1'b0;
        test_reset();
        test_scan_frames();
        test_snapshot_coherency();
        test_illegal_digits();
        test_blink();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
